keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Drives and reads a 4x4 active-low matrix keypad, debounces presses and delivers one clean event per key to the lock controller. It is the producer side of the lock's digit/enter input: `digit_out` feeds `in_digit`, and `enter_out` feeds `enter_btn`. It runs on the fast system clock, and its level outputs are safe to sample from the lock's slow clock domain.

## Interface
- `SCAN_DIV`, default 1000: clocks each row is driven. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 250: consecutive full scans a condition must persist before it is accepted. Must be ≥ 1.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `col_in`  in  4  keypad columns, active-low, externally pulled up, asynchronous.
- `row_out`  out  4  row drive, active-low one-hot.
- `digit_out`  out  4  code of the last accepted non-enter key; held between presses.
- `key_valid`  out  1  one-clock pulse when a non-enter key is accepted.
- `enter_out`  out  1  high while an accepted `#` is held.
- `key_held`  out  1  high from acceptance of any key until its release is accepted.

## Operation
- **Key map**, row r (0–3) × col c (0–3), layout `1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D`.
  - Digits map to their values; A–D map to 0xA–0xD.
  - `*` maps to 0xE; `#` maps to 0xF and is the enter key.
- **Synchronizer:** `col_in` passes through a 2-flop synchronizer before any use.
- **Scan:**
  - A row index 0..3 advances every `SCAN_DIV` clocks, and `row_out` drives that row low.
  - Synchronized columns are sampled on the last clock of each row period.
  - A full scan ends at the row-3 sample. Its result is one of:
    - NONE: no low column seen;
    - SINGLE(code): exactly one key seen;
    - MULTI: two or more keys seen, anywhere in the scan.
  - The debounce FSM updates once per scan, on the clock after the row-3 sample.
- **Debounce FSM:** a scan counter `cnt` and a candidate register `cand`.
  - **IDLE**
    - SINGLE(k): go to CAND, with `cand`=k and `cnt`=1.
    - NONE or MULTI: stay.
  - **CAND**
    - SINGLE(cand): increment `cnt`.
    - When `cnt` reaches `DEBOUNCE_SCANS`: go to PRESSED and accept the key.
    - Any other result: go to IDLE.
  - **Accept**
    - Sets `key_held`=1.
    - If `cand`≠0xF: `digit_out`=`cand` and `key_valid` pulses one clock.
    - If `cand`=0xF: `enter_out`=1; `digit_out` is unchanged and `key_valid` does not pulse.
  - **PRESSED**
    - SINGLE(cand): stay.
    - Any other result: go to RELEASE with `cnt`=1.
  - **RELEASE**
    - SINGLE(cand): go back to PRESSED (a bounce); no new event.
    - Any other result: increment `cnt`.
    - At `DEBOUNCE_SCANS`: go to IDLE with `key_held`=0 and `enter_out`=0.
  - If `DEBOUNCE_SCANS`=1, acceptance and release occur on the first qualifying scan.
- **Lockout:** a second key pressed while one is accepted never generates an event until release completes. A key still held alone after release re-enters via IDLE→CAND.
- **Reset** (`reset`=0 on a clock edge), at any time:
  - Outputs: `row_out`=4'b1111, `digit_out`=0, `key_valid`=0, `enter_out`=0, `key_held`=0.
  - Internal: FSM to IDLE; row index, divider, `cnt`, `cand` and synchronizer cleared.
  - A press in progress is discarded.

## Timing
- The first clock after reset deasserts drives `row_out`=4'b1110.
- Scan period is 4·`SCAN_DIV` clocks.
- Column settling: the 2-flop synchronizer plus sampling on the last row clock gives ≥ `SCAN_DIV`−3 clocks of settling.
- **Press latency:** with a key stable from scan start, `key_valid`/`enter_out` rise 1 clock after the row-3 sample of the `DEBOUNCE_SCANS`-th qualifying scan.
- **Release latency:** `enter_out`/`key_held` fall 1 clock after the row-3 sample of the `DEBOUNCE_SCANS`-th non-matching scan.
- `key_valid` is exactly 1 clock wide.
- `digit_out` updates on the same clock `key_valid` rises and is stable until the next accept.
- Counter widths cover the parameter ranges with no wrap. The row index wraps 3→0.

## Test plan
Bench settings: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3. The keypad model pulls `col_in[c]` low while `row_out[r]`=0 and key (r,c) is pressed.

1. **Reset and scan order:** hold `reset`=0 for 3 clocks.
   - During reset: `row_out`=1111 and all outputs are 0.
   - After release: `row_out` cycles 1110, 1101, 1011, 0111, each lasting 4 clocks.
2. **Clean press of `5`** (r1,c1), held 6 scans:
   - Exactly one `key_valid`, with `digit_out`=5.
   - `key_held` rises with the pulse and falls 3 scans after the key is released.
3. **Bounce:** press `7` for 2 scans, none for 1, then `7` for 3 scans.
   - No pulse during the first 3 scans.
   - Then a single `key_valid` with `digit_out`=7.
4. **Enter `#`** (r3,c2) after a `5` has been accepted:
   - `enter_out`=1 after 3 scans; `key_valid` stays 0 and `digit_out` stays 5.
   - A 1-scan release glitch does not drop `enter_out`.
   - `enter_out`=0 3 scans after the real release.
5. **Multiple keys:**
   - `1`+`2` pressed together: no event.
   - Hold `3` (accepted, `digit_out`=3), then add `6`: no pulse while both are held.
   - Release `3`: exactly one pulse with `digit_out`=6.
6. **Reset mid-press:** assert `reset` while in CAND with `0` held.
   - No pulse.
   - After reset, with `0` still held, exactly one pulse with `digit_out`=0 after 3 full scans.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with per-scan debounce and a single event per accepted key.
// Latency: key_valid/enter_out rise 1 clk after the row-3 sample of the DEBOUNCE_SCANS-th matching scan.
// Backpressure: none; key_valid is a 1-clk pulse, digit_out/enter_out/key_held are held levels.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   col_in     keypad columns, active-low, asynchronous (synchronized internally)
//   row_out    active-low one-hot row drive (4'b1111 while in reset)
//   digit_out  code of last accepted non-enter key
//   key_valid  one-clock pulse per accepted non-enter key
//   enter_out  high while an accepted '#' is held
//   key_held   high from acceptance of any key until its release is accepted
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] digit_out,
  output logic       key_valid,
  output logic       enter_out,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [3:0]       ENTER_KEY = 4'hF;

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D   ('*' = E, '#' = F)
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // ---------------- scan section ----------------
  logic [3:0]       col_s1, col_s2;
  logic [1:0]       row_idx;
  logic [DIV_W-1:0] div;
  logic             acc_seen, acc_multi;
  logic [3:0]       acc_code;
  logic             scan_done, res_single;
  logic [3:0]       res_code;

  logic [3:0] col_low;
  logic       col_any, col_one;
  logic [1:0] col_idx, row_nxt;
  logic       seen_n, multi_n;
  logic [3:0] code_n;

  always_comb begin
    col_low = ~col_s2;
    col_any = |col_low;
    col_one = col_any && ((col_low & (col_low - 4'd1)) == 4'd0);
    col_idx = 2'd0;
    case (col_low)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    row_nxt = row_idx + 2'd1;
    // Scan accumulation: a second key, in this row or an earlier one, makes the scan MULTI.
    seen_n  = acc_seen | col_any;
    multi_n = acc_multi | (col_any && (!col_one || acc_seen));
    code_n  = (col_one && !acc_seen) ? key_code(row_idx, col_idx) : acc_code;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Synchronizer clears to the idle (pulled-up) column level.
      col_s1     <= 4'hF;
      col_s2     <= 4'hF;
      row_idx    <= 2'd0;
      div        <= '0;
      row_out    <= 4'hF;
      acc_seen   <= 1'b0;
      acc_multi  <= 1'b0;
      acc_code   <= 4'h0;
      scan_done  <= 1'b0;
      res_single <= 1'b0;
      res_code   <= 4'h0;
    end else begin
      col_s1    <= col_in;
      col_s2    <= col_s1;
      scan_done <= 1'b0;
      if (row_out == 4'hF) begin
        // All rows high only right after reset: start row 0 now.
        row_out <= 4'b1110;
      end else if (div == DIV_LAST) begin
        div     <= '0;
        row_idx <= row_nxt;
        row_out <= ~(4'b0001 << row_nxt);
        if (row_idx == 2'd3) begin
          scan_done  <= 1'b1;
          res_single <= seen_n && !multi_n;
          res_code   <= code_n;
          acc_seen   <= 1'b0;
          acc_multi  <= 1'b0;
          acc_code   <= 4'h0;
        end else begin
          acc_seen  <= seen_n;
          acc_multi <= multi_n;
          acc_code  <= code_n;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // ---------------- debounce FSM ----------------
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;

  logic             match, accept_now, release_now;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       accept_code;

  always_comb begin
    match       = res_single && (res_code == cand);
    cnt_inc     = cnt + CNT_W'(1);
    accept_code = (state == IDLE) ? res_code : cand;
    // With a single-scan debounce the IDLE->CAND and PRESSED->RELEASE steps collapse.
    accept_now  = scan_done &&
                  ((state == IDLE && res_single && DEBOUNCE_SCANS == 1) ||
                   (state == CAND && match && cnt_inc == CNT_DONE));
    release_now = scan_done &&
                  ((state == PRESSED && !match && DEBOUNCE_SCANS == 1) ||
                   (state == RELEASE && !match && cnt_inc == CNT_DONE));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'h0;
      digit_out <= 4'h0;
      key_valid <= 1'b0;
      enter_out <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: if (res_single) begin
            cand  <= res_code;
            cnt   <= CNT_ONE;
            state <= (DEBOUNCE_SCANS == 1) ? PRESSED : CAND;
          end
          CAND: begin
            if (!match)                   state <= IDLE;
            else if (cnt_inc == CNT_DONE) state <= PRESSED;
            else                          cnt   <= cnt_inc;
          end
          PRESSED: if (!match) begin
            cnt   <= CNT_ONE;
            state <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
          end
          RELEASE: begin
            if (match)                    state <= PRESSED;   // bounce, no new event
            else if (cnt_inc == CNT_DONE) state <= IDLE;
            else                          cnt   <= cnt_inc;
          end
          default: state <= IDLE;
        endcase
      end
      if (accept_now) begin
        key_held <= 1'b1;
        if (accept_code == ENTER_KEY) begin
          enter_out <= 1'b1;
        end else begin
          digit_out <= accept_code;
          key_valid <= 1'b1;
        end
      end
      if (release_now) begin
        key_held  <= 1'b0;
        enter_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed keypad scenarios then random key sets against a scan-level model.
// Latency: model predicts outputs per clock; outputs compared on every falling edge.
// Backpressure: none; key sets change only at scan boundaries so every scan sees one stable set.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DEB  = 3;
  localparam int SCAN = 4 * SD;

  localparam int K1 = 0, K2 = 1, K3 = 2, K5 = 5, K6 = 6, K7 = 8, K0 = 13, KH = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_in, row_out, digit_out;
  logic       key_valid, enter_out, key_held;
  logic [15:0] keys = 16'h0;   // bit r*4+c = key (r,c) pressed

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .digit_out(digit_out), .key_valid(key_valid), .enter_out(enter_out), .key_held(key_held)
  );

  // Keypad: a pressed key ties its column to its row when that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && row_out[r] == 1'b0) col_in[c] = 1'b0;
  end

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] rows_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int tests = 0, fails = 0, pulses = 0;
  bit chk_en = 1'b0;

  // Model state
  int          k;            // clock edges since reset released
  logic [15:0] cur_keys = 16'h0, done_keys;
  bit          held;
  logic [3:0]  cand;
  int          streak, miss;
  logic [3:0]  exp_row, exp_digit;
  logic        exp_valid, exp_enter, exp_held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One completed scan: key count decides NONE/SINGLE/MULTI; streak counts consecutive
  // sightings of one candidate (a different key abandons it), miss counts scans without the held key.
  task automatic model_apply(input logic [15:0] ks);
    int n;
    logic [3:0] code;
    n = $countones(ks);
    code = 4'h0;
    for (int i = 0; i < 16; i++) if (ks[i]) code = kmap[i];
    if (!held) begin
      if (n == 1 && (streak == 0 || code == cand)) begin
        if (streak == 0) cand = code;
        streak++;
      end else begin
        streak = 0;
      end
      if (streak == DEB) begin
        held = 1'b1; streak = 0; miss = 0; exp_held = 1'b1;
        if (cand == 4'hF) exp_enter = 1'b1;
        else begin exp_digit = cand; exp_valid = 1'b1; end
      end
    end else begin
      if (n == 1 && code == cand) miss = 0;
      else miss++;
      if (miss == DEB) begin
        held = 1'b0; exp_held = 1'b0; exp_enter = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    if (!reset) begin
      k = 0; held = 1'b0; streak = 0; miss = 0; cand = 4'h0; done_keys = 16'h0;
      exp_row = 4'hF; exp_digit = 4'h0; exp_valid = 1'b0; exp_enter = 1'b0; exp_held = 1'b0;
    end else begin
      k++;
      exp_valid = 1'b0;
      // Outputs follow one clock after the row-3 sample that ends a scan.
      if (k >= 2 + SCAN && (k - 2) % SCAN == 0) model_apply(done_keys);
      if (k >= 1 + SCAN && (k - 1) % SCAN == 0) done_keys = cur_keys;
      exp_row = ~(4'b0001 << (((k - 1) / SD) % 4));
    end
  endtask

  task automatic run_scan(input logic [15:0] ks, input int n);
    repeat (n) begin
      keys = ks;
      cur_keys = ks;
      repeat (SCAN) step();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({row_out, digit_out, key_valid, enter_out, key_held} !==
          {exp_row, exp_digit, exp_valid, exp_enter, exp_held}) begin
        fails++;
        $display("FAIL model_cmp t=%0t k=%0d got row=%b dig=%h v=%b e=%b h=%b expected row=%b dig=%h v=%b e=%b h=%b",
                 $time, k, row_out, digit_out, key_valid, enter_out, key_held,
                 exp_row, exp_digit, exp_valid, exp_enter, exp_held);
      end
      if (key_valid === 1'b1) pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [15:0] nk;

    // 1: reset and scan order
    reset = 1'b0;
    repeat (3) step();
    chk("rst_row", row_out, 4'hF);
    chk("rst_outs", {digit_out, key_valid, enter_out, key_held}, 7'd0);
    reset = 1'b1;
    step();
    for (int i = 0; i < SCAN; i++) begin
      chk("scan_order", row_out, rows_lit[i / SD]);
      step();
    end

    // 2: clean press of 5
    p0 = pulses;
    run_scan(16'h1 << K5, 4);
    chk("p2_held", key_held, 1'b1);
    run_scan(16'h1 << K5, 2);
    run_scan(16'h0, 2);
    chk("p2_held_rel", key_held, 1'b1);
    run_scan(16'h0, 2);
    chk("p2_pulses", pulses - p0, 1);
    chk("p2_digit", digit_out, 4'h5);
    chk("p2_released", key_held, 1'b0);

    // 3: bounce on 7
    p0 = pulses;
    run_scan(16'h1 << K7, 2);
    run_scan(16'h0, 1);
    chk("p3_no_pulse", pulses - p0, 0);
    run_scan(16'h1 << K7, 4);
    run_scan(16'h0, 4);
    chk("p3_pulses", pulses - p0, 1);
    chk("p3_digit", digit_out, 4'h7);

    // 4: enter after a 5
    run_scan(16'h1 << K5, 4);
    run_scan(16'h0, 4);
    p0 = pulses;
    run_scan(16'h1 << KH, 4);
    chk("p4_enter", enter_out, 1'b1);
    chk("p4_no_pulse", pulses - p0, 0);
    chk("p4_digit", digit_out, 4'h5);
    run_scan(16'h0, 1);
    run_scan(16'h1 << KH, 2);
    chk("p4_glitch", enter_out, 1'b1);
    run_scan(16'h0, 4);
    chk("p4_enter_rel", enter_out, 1'b0);
    chk("p4_no_pulse2", pulses - p0, 0);

    // 5: multiple keys
    p0 = pulses;
    run_scan((16'h1 << K1) | (16'h1 << K2), 4);
    chk("p5_multi", pulses - p0, 0);
    run_scan(16'h0, 1);
    run_scan(16'h1 << K3, 4);
    chk("p5_digit3", digit_out, 4'h3);
    p0 = pulses;
    run_scan((16'h1 << K3) | (16'h1 << K6), 5);
    chk("p5_lockout", pulses - p0, 0);
    run_scan(16'h1 << K6, 5);
    chk("p5_pulses6", pulses - p0, 1);
    chk("p5_digit6", digit_out, 4'h6);
    run_scan(16'h0, 4);

    // 6: reset while a 0 is a candidate
    p0 = pulses;
    run_scan(16'h1 << K0, 2);
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    chk("p6_no_pulse", pulses - p0, 0);
    chk("p6_rst_digit", digit_out, 4'h0);
    reset = 1'b1;
    step();
    run_scan(16'h1 << K0, 4);
    chk("p6_pulses", pulses - p0, 1);
    chk("p6_digit", digit_out, 4'h0);
    run_scan(16'h0, 4);

    // Random key sets, held across scans often enough to debounce, with occasional resets.
    nk = 16'h0;
    for (int s = 0; s < 150; s++) begin
      int r;
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        reset = 1'b1;
        step();
      end
      r = $urandom_range(0, 99);
      if (r < 55)      nk = nk;
      else if (r < 70) nk = 16'h0;
      else if (r < 92) nk = 16'h1 << $urandom_range(0, 15);
      else             nk = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      run_scan(nk, 1);
    end
    run_scan(16'h0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
